usb_dev_txn_responder: RTL

Device-side (function-end) USB transaction responder: the peer of the host controller's transaction engine.
- Consumes decoded tokens and data packets from a device SIE.
- Answers IN tokens with DATA0/DATA1 (or NAK/STALL) and OUT/SETUP tokens with ACK/NAK/STALL.
- Keeps per-endpoint data toggles and talks byte-wise to application endpoint buffers.
- Single SIE-side clock domain.

---
 rtl/usb_dev_pkg.sv | 27 ++
 rtl/usb_dev_toggle_bank.sv | 27 ++
 rtl/usb_dev_txn_responder.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_dev_pkg.sv
// Shared PID codes, FSM states and OUT disposition for the USB device transaction responder.
package usb_dev_pkg;

    localparam logic [3:0] PidOut   = 4'b0001;
    localparam logic [3:0] PidIn    = 4'b1001;
    localparam logic [3:0] PidSetup = 4'b1101;
    localparam logic [3:0] PidData0 = 4'b0011;
    localparam logic [3:0] PidData1 = 4'b1011;
    localparam logic [3:0] PidAck   = 4'b0010;
    localparam logic [3:0] PidNak   = 4'b1010;
    localparam logic [3:0] PidStall = 4'b1110;

    typedef enum logic [2:0] {
        StIdle,
        StTxData,
        StWaitAck,
        StRxData,
        StTxHs
    } state_e;

    typedef enum logic [1:0] {
        DispAccept,
        DispNak,
        DispStall
    } disp_e;

endpackage

// File: rtl/usb_dev_toggle_bank.sv
// Per-endpoint DATA0/DATA1 toggle bits with a single indexed flip/clear/read port.
module usb_dev_toggle_bank #(
    parameter int unsigned NUM_EP = 4,
    parameter int unsigned EP_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [EP_W-1:0]   idx,
    input  logic              flip,
    input  logic              clear,
    output logic              rd,
    output logic [NUM_EP-1:0] toggle
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toggle <= '0;
        end else if (clear) begin
            toggle[idx] <= 1'b0;
        end else if (flip) begin
            toggle[idx] <= ~toggle[idx];
        end
    end

    assign rd = toggle[idx];

endmodule

// File: rtl/usb_dev_txn_responder.sv
// Device-side USB transaction responder: answers IN/OUT/SETUP tokens and keeps data toggles.
// Build option USB_DEV_ERR_CNT_EN adds err_cnt, a saturating CRC/overflow/timeout count.
module usb_dev_txn_responder
    import usb_dev_pkg::*;
#(
    parameter int unsigned NUM_EP   = 4,
    parameter int unsigned MAX_PKT  = 64,
    parameter int unsigned TURN_TMO = 64,
    parameter int unsigned LEN_W    = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        dev_addr,
    input  logic [NUM_EP-1:0] ep_stall,
    input  logic              tok_valid,
    input  logic [3:0]        tok_pid,
    input  logic [6:0]        tok_addr,
    input  logic [3:0]        tok_ep,
    input  logic              rx_start,
    input  logic [3:0]        rx_pid,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic              rx_end,
    input  logic              rx_crc_ok,
    input  logic              hs_valid,
    input  logic [3:0]        hs_pid,
    output logic              tx_valid,
    output logic [3:0]        tx_pid,
    output logic [7:0]        tx_byte,
    output logic              tx_last,
    input  logic              tx_ready,
    input  logic [NUM_EP-1:0] in_armed,
    input  logic [LEN_W-1:0]  in_len,
    output logic [3:0]        in_ep,
    output logic              in_rd,
    input  logic [7:0]        in_rd_data,
    output logic              in_done,
    input  logic [NUM_EP-1:0] out_ready,
    output logic              out_wr,
    output logic [7:0]        out_wr_data,
    output logic              out_commit,
    output logic              out_abort,
    output logic [NUM_EP-1:0] toggle,
    output logic              busy
`ifdef USB_DEV_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam int unsigned EpW  = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
    localparam int unsigned TmoW = $clog2(TURN_TMO + 1);
    localparam int unsigned OcW  = $clog2(MAX_PKT + 1);
    localparam logic [TmoW-1:0]  TmoLast = TmoW'(TURN_TMO - 1);
    localparam logic [OcW-1:0]   OcMax   = OcW'(MAX_PKT);
    localparam logic [LEN_W-1:0] LenMax  = LEN_W'(MAX_PKT);

    state_e            state_q, state_d;
    disp_e             disp_q, disp_d;
    logic [3:0]        ep_q, ep_d;
    logic [3:0]        hs_pid_q, hs_pid_d;
    logic [LEN_W-1:0]  bcnt_q, bcnt_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic [OcW-1:0]    ocnt_q, ocnt_d;
    logic              ovf_q, ovf_d;
    logic              started_q, started_d;
    logic              rx_tog_q, rx_tog_d;

    logic              tok_hit, tog_flip, tog_clear, tog_rd, err_inc, ovf_now;
    logic [EpW-1:0]    tok_idx, tog_idx;
    logic [LEN_W-1:0]  eff_len;

    assign tok_idx = tok_ep[EpW-1:0];
    assign tok_hit = tok_valid && (state_q == StIdle) && (tok_addr == dev_addr)
                     && (32'(tok_ep) < NUM_EP)
                     && (tok_pid == PidIn || tok_pid == PidOut || tok_pid == PidSetup);
    // The bank is addressed by the incoming token while idle so SETUP can clear on acceptance.
    assign tog_idx = (state_q == StIdle) ? tok_idx : ep_q[EpW-1:0];
    assign eff_len = (32'(in_len) > MAX_PKT) ? LenMax : in_len;
    assign in_ep   = ep_q;
    assign busy    = (state_q != StIdle);

    usb_dev_toggle_bank #(
        .NUM_EP (NUM_EP),
        .EP_W   (EpW)
    ) u_toggle_bank (
        .clk    (clk),
        .rst    (rst),
        .idx    (tog_idx),
        .flip   (tog_flip),
        .clear  (tog_clear),
        .rd     (tog_rd),
        .toggle (toggle)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            disp_q    <= DispAccept;
            ep_q      <= '0;
            hs_pid_q  <= '0;
            bcnt_q    <= '0;
            tmo_q     <= '0;
            ocnt_q    <= '0;
            ovf_q     <= 1'b0;
            started_q <= 1'b0;
            rx_tog_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            disp_q    <= disp_d;
            ep_q      <= ep_d;
            hs_pid_q  <= hs_pid_d;
            bcnt_q    <= bcnt_d;
            tmo_q     <= tmo_d;
            ocnt_q    <= ocnt_d;
            ovf_q     <= ovf_d;
            started_q <= started_d;
            rx_tog_q  <= rx_tog_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        disp_d      = disp_q;
        ep_d        = ep_q;
        hs_pid_d    = hs_pid_q;
        bcnt_d      = bcnt_q;
        tmo_d       = '0;
        ocnt_d      = ocnt_q;
        ovf_d       = ovf_q;
        started_d   = started_q;
        rx_tog_d    = rx_tog_q;
        tx_valid    = 1'b0;
        tx_pid      = '0;
        tx_byte     = '0;
        tx_last     = 1'b0;
        in_rd       = 1'b0;
        in_done     = 1'b0;
        out_wr      = 1'b0;
        out_wr_data = '0;
        out_commit  = 1'b0;
        out_abort   = 1'b0;
        tog_flip    = 1'b0;
        tog_clear   = 1'b0;
        err_inc     = 1'b0;
        ovf_now     = ovf_q || (rx_valid && ocnt_q == OcMax);

        unique case (state_q)
            StIdle: begin
                if (tok_hit) begin
                    ep_d      = tok_ep;
                    bcnt_d    = '0;
                    ocnt_d    = '0;
                    ovf_d     = 1'b0;
                    started_d = 1'b0;
                    if (tok_pid == PidIn) begin
                        if (ep_stall[tok_idx]) begin
                            hs_pid_d = PidStall;
                            state_d  = StTxHs;
                        end else if (!in_armed[tok_idx]) begin
                            hs_pid_d = PidNak;
                            state_d  = StTxHs;
                        end else begin
                            state_d = StTxData;
                        end
                    end else begin
                        state_d = StRxData;
                        if (tok_pid == PidSetup) begin
                            disp_d    = DispAccept;
                            tog_clear = 1'b1;
                        end else if (ep_stall[tok_idx]) begin
                            disp_d = DispStall;
                        end else if (!out_ready[tok_idx]) begin
                            disp_d = DispNak;
                        end else begin
                            disp_d = DispAccept;
                        end
                    end
                end
            end
            StTxData: begin
                // Beat 0 carries the PID; beats 1..eff_len carry the buffer head bytes.
                tx_valid = 1'b1;
                tx_pid   = tog_rd ? PidData1 : PidData0;
                tx_last  = (bcnt_q == eff_len);
                tx_byte  = (bcnt_q == '0) ? 8'h00 : in_rd_data;
                if (tx_ready) begin
                    in_rd = (bcnt_q != '0);
                    if (tx_last) begin
                        state_d = StWaitAck;
                    end else begin
                        bcnt_d = bcnt_q + LEN_W'(1);
                    end
                end
            end
            StWaitAck: begin
                tmo_d = tmo_q + TmoW'(1);
                if (hs_valid) begin
                    state_d = StIdle;
                    if (hs_pid == PidAck) begin
                        tog_flip = 1'b1;
                        in_done  = 1'b1;
                    end
                end else if (tmo_q == TmoLast) begin
                    state_d = StIdle;
                    err_inc = 1'b1;
                end
            end
            StRxData: begin
                if (!started_q) begin
                    tmo_d = tmo_q + TmoW'(1);
                    if (rx_start) begin
                        started_d = 1'b1;
                        rx_tog_d  = rx_pid[3];
                    end else if (tmo_q == TmoLast) begin
                        state_d = StIdle;
                        err_inc = 1'b1;
                    end
                end else begin
                    if (rx_valid) begin
                        if (ocnt_q == OcMax) begin
                            ovf_d = 1'b1;
                        end else begin
                            ocnt_d = ocnt_q + OcW'(1);
                            if (disp_q == DispAccept) begin
                                out_wr      = 1'b1;
                                out_wr_data = rx_byte;
                            end
                        end
                    end
                    if (rx_end) begin
                        if (!rx_crc_ok || ovf_now) begin
                            out_abort = (disp_q == DispAccept);
                            err_inc   = 1'b1;
                            state_d   = StIdle;
                        end else if (disp_q != DispAccept) begin
                            hs_pid_d = (disp_q == DispStall) ? PidStall : PidNak;
                            state_d  = StTxHs;
                        end else begin
                            // A toggle mismatch is a host retry of a packet we already kept.
                            hs_pid_d = PidAck;
                            state_d  = StTxHs;
                            if (rx_tog_q != tog_rd) begin
                                out_abort = 1'b1;
                            end else begin
                                out_commit = 1'b1;
                                tog_flip   = 1'b1;
                            end
                        end
                    end
                end
            end
            StTxHs: begin
                tx_valid = 1'b1;
                tx_pid   = hs_pid_q;
                tx_last  = 1'b1;
                if (tx_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    logic unused_rx_pid;
    assign unused_rx_pid = ^rx_pid[2:0];

`ifdef USB_DEV_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_inc && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    logic unused_err_inc;
    assign unused_err_inc = err_inc;
`endif

endmodule
